uart_tx_queue: RTL and testbench

Byte queue and launch controller sitting directly upstream of the async UART transmitter.
- Accepts bytes from the CPU/peripheral bus side into a synchronous FIFO.
- Feeds them one at a time to the transmitter: pulses tx_start with tx_data, then tracks tx_busy to completion.
- Lets software write bursts without polling the transmitter per byte.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_queue_if.sv | 43 ++++
 rtl/uart_byte_fifo.sv | 68 ++++++
 rtl/uart_tx_queue.sv | 140 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;

  localparam int UART_BYTE_W      = 8;
  localparam int TXQ_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bus/transmitter-side signal bundle for uart_tx_queue.
// UART_TXQ_IRQ_EN adds irq / irq_thresh.
interface uart_tx_queue_if import uart_pkg::*; #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic                   wr_en;
  logic [UART_BYTE_W-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [AW:0]            level;
  logic                   overflow;
  logic                   ovf_clr;
  logic                   tx_start;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   tx_busy;
  logic                   tx_done;
  logic                   idle;
`ifdef UART_TXQ_IRQ_EN
  logic                   irq;
  logic [AW:0]            irq_thresh;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_busy, irq_thresh,
    input  full, empty, level, overflow, tx_start, tx_data, tx_done, idle, irq
  );
  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_busy, irq_thresh,
    output full, empty, level, overflow, tx_start, tx_data, tx_done, idle, irq
  );
`else
  modport master (
    output wr_en, wr_data, ovf_clr, tx_busy,
    input  full, empty, level, overflow, tx_start, tx_data, tx_done, idle
  );
  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_busy,
    output full, empty, level, overflow, tx_start, tx_data, tx_done, idle
  );
`endif

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty/level.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [W-1:0]           i_wr_data,
  input  logic                   i_rd_en,
  output logic [W-1:0]           o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;

  assign w_push    = i_wr_en & ~r_full;
  assign w_pop     = i_rd_en & ~r_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_level   = r_count;

  // Next occupancy from accepted push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage write (no reset needed on data)
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and registered status flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch controller ahead of the UART transmitter.
// Optional macro UART_TXQ_IRQ_EN adds a registered threshold interrupt.
module uart_tx_queue import uart_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] TO_LAST = 2'(TXQ_BUSY_TIMEOUT - 1);

  txq_state_e             r_state;
  txq_state_e             w_state_nxt;
  logic                   r_tx_start;
  logic                   w_tx_start_nxt;
  logic [UART_BYTE_W-1:0] r_tx_data;
  logic [UART_BYTE_W-1:0] w_tx_data_nxt;
  logic                   r_tx_done;
  logic                   w_tx_done_nxt;
  logic [1:0]             r_to_cnt;
  logic [1:0]             w_to_cnt_nxt;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [AW:0]            w_level;
  logic [UART_BYTE_W-1:0] w_head;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_BYTE_W)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (bus.wr_en),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.level    = w_level;
  assign bus.overflow = r_overflow;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_done  = r_tx_done;
  assign bus.idle     = w_empty & (r_state == IDLE) & ~bus.tx_busy;

  // Launch FSM: next state, pop request and next registered outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_tx_done_nxt  = 1'b0;
    w_to_cnt_nxt   = r_to_cnt;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !bus.tx_busy) begin
          w_pop          = 1'b1;
          w_tx_data_nxt  = w_head;
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = LAUNCH;
        end
      end
      LAUNCH: begin
        w_to_cnt_nxt = '0;
        w_state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_state_nxt = WAIT_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          // transmitter never acknowledged: treat byte as sent
          w_tx_done_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!bus.tx_busy) begin
          w_tx_done_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state and launch/done output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_tx_done  <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_done  <= w_tx_done_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
    end
  end

  // Sticky overflow; a dropped write wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_en && w_full) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef UART_TXQ_IRQ_EN
  logic r_irq;

  // Low-water interrupt while no byte is being launched/awaited
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_level <= bus.irq_thresh) &&
               ((r_state == IDLE) || (r_state == WAIT_IDLE));
    end
  end

  assign bus.irq = r_irq;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a simple transmitter model.
module tb_uart_tx_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_queue_if #(.DEPTH(16)) bus ();

  uart_tx_queue #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Transmitter model: goes busy for m_len cycles after each observed tx_start
  logic       m_busy = 1'b0;
  logic       m_hold = 1'b0;
  int         m_cnt  = 0;
  int         m_len  = 3;
  bit         m_en   = 1'b1;
  logic [7:0] sent_q[$];
  int         n_start = 0;
  int         n_start_busy = 0;

  assign bus.tx_busy = m_busy | m_hold;

  always @(posedge clk) begin
    if (bus.tx_start && m_en) begin
      m_busy <= 1'b1;
      m_cnt  <= m_len;
      sent_q.push_back(bus.tx_data);
    end else if (m_busy) begin
      if (m_cnt <= 1) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (bus.tx_start) begin
      n_start++;
      if (bus.tx_busy) n_start_busy++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.idle) break;
      tick();
    end
    check_eq(tag, {31'd0, bus.idle}, 32'd1);
  endtask

  initial begin
    int k;
    int ns;
    int n_ee;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
`ifdef UART_TXQ_IRQ_EN
    bus.irq_thresh = '0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_empty",    {31'd0, bus.empty},    32'd1);
    check_eq("rst_full",     {31'd0, bus.full},     32'd0);
    check_eq("rst_level",    32'(bus.level),        32'd0);
    check_eq("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check_eq("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check_eq("rst_tx_data",  32'(bus.tx_data),      32'h00);
    check_eq("rst_tx_done",  {31'd0, bus.tx_done},  32'd0);
    check_eq("rst_idle",     {31'd0, bus.idle},     32'd1);

    // Single byte: launch two edges after the write, done after busy falls
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check_eq("sb_level_E",  32'(bus.level),        32'd1);
    check_eq("sb_start_E",  {31'd0, bus.tx_start}, 32'd0);
    tick();
    check_eq("sb_start_E1", {31'd0, bus.tx_start}, 32'd1);
    check_eq("sb_data_E1",  32'(bus.tx_data),      32'hA5);
    check_eq("sb_empty_E1", {31'd0, bus.empty},    32'd1);
    k = 0;
    while (!bus.tx_done && k < 20) begin
      tick();
      k++;
    end
    check_eq("sb_done_lat", 32'(k), 32'd5);
    tick();
    check_eq("sb_done_pulse", {31'd0, bus.tx_done}, 32'd0);
    check_eq("sb_idle",       {31'd0, bus.idle},    32'd1);
    check_eq("sb_data_hold",  32'(bus.tx_data),     32'hA5);
    check_eq("sb_sent",       32'(sent_q[0]),       32'hA5);

    // Burst of 16 with transmitter held busy, then drain
    sent_q.delete();
    ns = n_start;
    m_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i + 1);
      tick();
    end
    bus.wr_en = 1'b0;
    check_eq("bu_full",  {31'd0, bus.full}, 32'd1);
    check_eq("bu_level", 32'(bus.level),    32'd16);
    m_hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (sent_q.size() == 16 && bus.idle) break;
      tick();
    end
    check_eq("bu_count",  32'(sent_q.size()), 32'd16);
    check_eq("bu_starts", 32'(n_start - ns),  32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < sent_q.size()) check_eq("bu_order", 32'(sent_q[i]), 32'(i + 1));
    end

    // Overflow: drop when full, set beats clear, clear alone releases
    sent_q.delete();
    m_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + i);
      tick();
    end
    check_eq("ov_pre", {31'd0, bus.overflow}, 32'd0);
    bus.wr_data = 8'hFF;
    tick();
    check_eq("ov_set",   {31'd0, bus.overflow}, 32'd1);
    check_eq("ov_level", 32'(bus.level),        32'd16);
    bus.ovf_clr = 1'b1;
    tick();
    check_eq("ov_set_wins", {31'd0, bus.overflow}, 32'd1);
    bus.wr_en = 1'b0;
    tick();
    bus.ovf_clr = 1'b0;
    check_eq("ov_clr", {31'd0, bus.overflow}, 32'd0);

    // Push while full coinciding with a pop: write is still dropped
    m_hold = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    check_eq("pp_level",    32'(bus.level),        32'd15);
    check_eq("pp_full",     {31'd0, bus.full},     32'd0);
    check_eq("pp_overflow", {31'd0, bus.overflow}, 32'd1);
    check_eq("pp_start",    {31'd0, bus.tx_start}, 32'd1);
    check_eq("pp_data",     32'(bus.tx_data),      32'h20);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (sent_q.size() == 16 && bus.idle) break;
      tick();
    end
    check_eq("pp_count", 32'(sent_q.size()), 32'd16);
    n_ee = 0;
    foreach (sent_q[i]) if (sent_q[i] == 8'hEE) n_ee++;
    check_eq("pp_no_ee", 32'(n_ee), 32'd0);
    if (sent_q.size() == 16) check_eq("pp_last", 32'(sent_q[15]), 32'h2F);

    // Reset while bytes are queued and the transmitter is busy
    m_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h50 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    check_eq("rm_level_pre", 32'(bus.level), 32'd5);
    rst = 1'b1;
    #1;
    check_eq("rm_empty", {31'd0, bus.empty},    32'd1);
    check_eq("rm_level", 32'(bus.level),        32'd0);
    check_eq("rm_start", {31'd0, bus.tx_start}, 32'd0);
    tick();
    rst = 1'b0;
    ns = n_start;
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    repeat (4) tick();
    check_eq("rm_no_start", 32'(n_start - ns), 32'd0);
    check_eq("rm_level_q",  32'(bus.level),    32'd1);
    m_hold = 1'b0;
    tick();
    check_eq("rm_start_ok", {31'd0, bus.tx_start}, 32'd1);
    check_eq("rm_data",     32'(bus.tx_data),      32'h3C);
    wait_idle(100, "rm_idle");

    // Busy timeout: transmitter ignores tx_start
    m_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'h61;
    tick();
    check_eq("to_start_E", {31'd0, bus.tx_start}, 32'd0);
    bus.wr_data = 8'h62;
    tick();
    bus.wr_en = 1'b0;
    check_eq("to_start1", {31'd0, bus.tx_start}, 32'd1);
    check_eq("to_data1",  32'(bus.tx_data),      32'h61);
    repeat (4) tick();
    check_eq("to_done_early", {31'd0, bus.tx_done}, 32'd0);
    tick();
    check_eq("to_done", {31'd0, bus.tx_done}, 32'd1);
    tick();
    check_eq("to_done_pulse", {31'd0, bus.tx_done},  32'd0);
    check_eq("to_start2",     {31'd0, bus.tx_start}, 32'd1);
    check_eq("to_data2",      32'(bus.tx_data),      32'h62);
    wait_idle(20, "to_idle");
    m_en = 1'b1;

    check_eq("start_while_busy", 32'(n_start_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
